instr_prefetch: RTL

Instruction prefetch stage sitting between the RAM and the InstructionRegister. It owns the program counter for sequential fetch, issues word reads to the RAM whenever the MemoryControl path is not using the bus, and buffers returned words in a small queue. Words are presented to the decode side with a valid/ready handshake; a redirect (branch/jump) flushes the queue and restarts fetch.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/prefetch_fifo.sv | 76 +++++++
 rtl/instr_prefetch.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_pkg : shared CPU constants and the fetch-stage state encoding
// Rev 1.0
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int WORD_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// prefetch_fifo : shift-style queue; entry 0 is always the registered head
// Rev 1.0
// ----------------------------------------------------------------------------
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d, wr_idx;
  logic             empty_q, empty_d;
  logic             do_pop, do_push;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_idx  = count_q - CNT_W'(do_pop);
    if (flush) begin
      count_d = '0;
    end else begin
      // The last entry is left in place on its pop so the head holds its value.
      if (do_pop && (count_q > CNT_W'(1))) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          mem_d[i] = mem_q[i+1];
        end
      end
      if (do_push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_idx == CNT_W'(i)) begin
            mem_d[i] = wdata;
          end
        end
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      count_q <= '0;
      empty_q <= 1'b1;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
      empty_q <= empty_d;
    end
  end

  assign head  = mem_q[0];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = empty_q;
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/instr_prefetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_prefetch : sequential fetch, RAM read issue, prefetch queue, redirect.
// Optional PREFETCH_STATS_EN adds stall_count / flush_count.  Rev 1.0
// ----------------------------------------------------------------------------
module instr_prefetch
  import cpu_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                DATA_W   = cpu_pkg::WORD_W,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_busy,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]       stall_count,
  output logic [15:0]       flush_count
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = DATA_W + ADDR_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              inflight_q, inflight_d;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic [ENT_W-1:0]  fifo_head;
  logic              has_room, issue, kill, push;

  // Reserve a slot for the word already on its way back from the RAM.
  assign has_room = !fifo_full &&
                    (({1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q}) < (CNT_W+1)'(DEPTH));
  assign kill     = redirect;
  assign push     = inflight_q && !kill;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    issue      = 1'b0;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     issue   = !mem_busy && !redirect && has_room;
      REDIR:   state_d = RUN;
      default: state_d = BOOT;
    endcase
    if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      tag_d      = fetch_pc_q;
      inflight_d = 1'b1;
    end
    if (redirect) begin
      state_d    = REDIR;
      fetch_pc_d = redirect_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({ram_data, tag_q}),
    .pop   (instr_ready),
    .flush (redirect),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign ram_rd      = issue;
  assign ram_addr    = fetch_pc_q;
  assign instr       = fifo_head[ENT_W-1:ADDR_W];
  assign instr_pc    = fifo_head[ADDR_W-1:0];
  assign instr_valid = !fifo_empty;

`ifdef PREFETCH_STATS_EN
  logic [15:0] stall_q, stall_d;
  logic [15:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if ((state_q == RUN) && (mem_busy || !has_room) && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
    if (redirect && (flush_q != 16'hFFFF)) begin
      flush_d = flush_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
`endif

endmodule
`default_nettype wire
